// File: rtl/dest_reg_pipe.sv
//------------------------------------------------------------------------------
// Module   : dest_reg_pipe
// Brief    : Destination-register select plus per-stage {dest, we} tracking
//            with stall/flush control and combinational hazard match flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dest_reg_pipe #(
    parameter int ADDR_W   = 5,
    parameter int STAGES   = 3,
    parameter int LINK_REG = 31
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [ADDR_W-1:0]          i_RT,
    input  logic [ADDR_W-1:0]          i_RD,
    input  logic [1:0]                 i_dest_sel,
    input  logic                       i_reg_write,
    input  logic                       i_valid,
    input  logic                       i_stall,
    input  logic                       i_flush,
    input  logic [ADDR_W-1:0]          i_RS_src,
    input  logic [ADDR_W-1:0]          i_RT_src,
    output logic [ADDR_W-1:0]          o_mux_RD,
    output logic [STAGES*ADDR_W-1:0]   o_stage_dest,
    output logic [STAGES-1:0]          o_stage_we,
    output logic [ADDR_W-1:0]          o_wb_dest,
    output logic                       o_wb_we,
    output logic [STAGES-1:0]          o_hazard_rs,
    output logic [STAGES-1:0]          o_hazard_rt
);

    localparam logic [1:0]        c_SEL_RD   = 2'b00;
    localparam logic [1:0]        c_SEL_RT   = 2'b01;
    localparam logic [1:0]        c_SEL_LINK = 2'b10;
    localparam logic [1:0]        c_SEL_NONE = 2'b11;
    localparam logic [ADDR_W-1:0] c_LINK     = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] c_ZERO     = '0;

    logic [ADDR_W-1:0] r_dest [STAGES];
    logic              r_we   [STAGES];

    logic [ADDR_W-1:0] w_mux;
    logic              w_we_in;

    always_comb begin
        w_mux = c_ZERO;
        case (i_dest_sel)
            c_SEL_RD:   w_mux = i_RD;
            c_SEL_RT:   w_mux = i_RT;
            c_SEL_LINK: w_mux = c_LINK;
            default:    w_mux = c_ZERO;
        endcase
    end

    // $0 is hardwired, so a write aimed at it is never tracked as pending
    assign w_we_in = i_valid & i_reg_write & (i_dest_sel != c_SEL_NONE) & (w_mux != c_ZERO);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_dest[0] <= c_ZERO;
            r_we[0]   <= 1'b0;
        end else if (i_flush) begin
            r_dest[0] <= c_ZERO;
            r_we[0]   <= 1'b0;
        end else if (!i_stall) begin
            r_dest[0] <= w_mux;
            r_we[0]   <= w_we_in;
        end
    end

    // A stall keeps the instruction in stage 0 and sends a bubble forward
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_dest[1] <= c_ZERO;
            r_we[1]   <= 1'b0;
        end else if (i_stall) begin
            r_dest[1] <= c_ZERO;
            r_we[1]   <= 1'b0;
        end else begin
            r_dest[1] <= r_dest[0];
            r_we[1]   <= r_we[0];
        end
    end

    genvar k;
    generate
        for (k = 2; k < STAGES; k++) begin : g_shift
            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) begin
                    r_dest[k] <= c_ZERO;
                    r_we[k]   <= 1'b0;
                end else begin
                    r_dest[k] <= r_dest[k-1];
                    r_we[k]   <= r_we[k-1];
                end
            end
        end

        for (k = 0; k < STAGES; k++) begin : g_out
            assign o_stage_dest[k*ADDR_W +: ADDR_W] = r_dest[k];
            assign o_stage_we[k]  = r_we[k];
            assign o_hazard_rs[k] = r_we[k] & (r_dest[k] == i_RS_src) & (i_RS_src != c_ZERO);
            assign o_hazard_rt[k] = r_we[k] & (r_dest[k] == i_RT_src) & (i_RT_src != c_ZERO);
        end
    endgenerate

    assign o_mux_RD  = r_dest[0];
    assign o_wb_dest = r_dest[STAGES-1];
    assign o_wb_we   = r_we[STAGES-1];

endmodule

`default_nettype wire

// File: doc/dest_reg_pipe.md
# dest_reg_pipe

Parametrised destination-register select and tracking pipeline for the MIPS five-stage core. It registers the selected write-back register (RD, RT or the link register) at the end of Instruction Decode. It carries that destination and its write enable through a configurable number of downstream stages with stall/flush control. It also flags every in-flight stage whose pending write matches the current source registers, so the forwarding and hazard units can use it directly.

## Interface
Parameters:
- ADDR_W, 5, register-address width in bits
- STAGES, 3, tracked stages (0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB); minimum 2
- LINK_REG, 31, destination used for JAL/JALR link writes

Ports:
- i_clk  input  1  rising-edge clock
- i_reset  input  1  asynchronous, active-low reset
- i_RT  input  ADDR_W  rt field of decoding instruction
- i_RD  input  ADDR_W  rd field of decoding instruction
- i_dest_sel  input  2  00 = RD, 01 = RT, 10 = LINK_REG, 11 = no destination
- i_reg_write  input  1  decoded register-write control
- i_valid  input  1  decoding instruction is real (not a bubble)
- i_stall  input  1  hold stage 0, insert bubble into stage 1
- i_flush  input  1  discard the decoding instruction
- i_RS_src  input  ADDR_W  rs of decoding instruction (hazard query)
- i_RT_src  input  ADDR_W  rt of decoding instruction (hazard query)
- o_mux_RD  output  ADDR_W  stage-0 destination
- o_stage_dest  output  STAGES*ADDR_W  destination per stage, stage k at bits [k*ADDR_W +: ADDR_W]
- o_stage_we  output  STAGES  write enable per stage
- o_wb_dest  output  ADDR_W  destination of stage STAGES-1
- o_wb_we  output  1  write enable of stage STAGES-1
- o_hazard_rs  output  STAGES  bit k is set when stage k writes i_RS_src
- o_hazard_rt  output  STAGES  bit k is set when stage k writes i_RT_src

## Operation
- Select logic (combinational): mux = RD / RT / LINK_REG / 0, chosen by i_dest_sel.
- Candidate write enable: we_in = i_valid & i_reg_write & (i_dest_sel != 11) & (mux != 0).
  - Writes to $0 never propagate as enabled.
- Each stage holds a pair {dest, we}. A bubble is {0, 0}.
- Stage-0 update, first matching rule wins:
  - i_flush: stage 0 becomes a bubble.
  - i_stall: stage 0 holds its value.
  - Otherwise: stage 0 captures {mux, we_in}.
- Stage-1 update:
  - i_stall: stage 1 becomes a bubble, regardless of i_flush.
  - Otherwise: stage 1 takes stage 0.
- Stages 2..STAGES-1 always shift (stage k takes stage k-1), independent of stall and flush.
- i_stall & i_flush together: stage 0 becomes a bubble, stage 1 becomes a bubble, higher stages shift.
- Hazard outputs (combinational from registered state and query inputs):
  - o_hazard_rs[k] = o_stage_we[k] & (stage k dest == i_RS_src) & (i_RS_src != 0).
  - o_hazard_rt[k] is the same rule applied to i_RT_src.
  - Multiple bits may be set at once; the consumer picks the lowest k.
- o_mux_RD equals stage-0 dest. o_wb_dest and o_wb_we mirror stage STAGES-1.

## Timing
- Reset (i_reset low, asynchronous): every stage dest = 0 and we = 0.
  - All outputs read 0 while reset is asserted and until the first capture after release.
- Release is synchronous to the next rising edge. The first edge with i_reset high performs a normal update.
- Latency: an instruction presented at edge N appears on o_mux_RD after edge N. It reaches stage k after edge N+k, and o_wb_* after edge N+STAGES-1 (no stalls).
- A stall cycle adds exactly one cycle of residency in stage 0 and one bubble downstream.
- Reset asserted mid-operation clears all in-flight destinations immediately. Nothing is retained.
- Hazard outputs settle within the same cycle that their inputs change. They carry no register delay.

## Test plan
- Reset/select: hold i_reset low → all outputs 0. Release, then i_RD=5, i_RT=9, i_dest_sel=00, valid=1, reg_write=1 → after 1 edge o_mux_RD=5, o_stage_we[0]=1. Next edge with sel=01 → o_mux_RD=9. Then sel=10 → 31.
- Pipeline/latency: issue dests 3, 4, 6 on consecutive edges (STAGES=3) → after edge 3, o_stage_dest = {3 (stage 2), 4, 6}, o_wb_dest=3, o_wb_we=1.
- $0 and no-dest suppression: sel=00 with i_RD=0 → stage-0 we=0. sel=11 with i_RD=7 → dest 0, we=0. reg_write=0 → we=0.
- Stall: stage 0 holds dest 8, assert i_stall for 1 edge → stage 0 still 8, stage 1 = bubble, stage 2 = old stage 1. Deassert → 8 moves to stage 1.
- Flush, and flush with stall: i_flush with incoming dest 12 → stage 0 bubble, old stage 0 shifts to stage 1. Both asserted → stages 0 and 1 are bubbles, stage 2 = old stage 1.
- Hazard: stage 0 dest 10 we=1, stage 2 dest 10 we=1, i_RS_src=10, i_RT_src=0 → o_hazard_rs=101, o_hazard_rt=000. Set stage 0 we=0 → o_hazard_rs=100.
